control_unit: RTL and testbench

//  Main control decoder of the single-cycle/pipelined LEGv8 datapath.

---
 rtl/control_unit.sv | 80 ++++++++
 tb/tb_control_unit.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// LEGv8 main control decoder: maps the 11-bit opcode field to datapath strobes.
// The decode is combinational and captured in output registers on the rising clock edge.
module control_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [10:0] instruction,
    output logic        NotZeroBranch,
    output logic        Reg2Loc,
    output logic        Uncondbranch,
    output logic        ZeroBranch,
    output logic        MemRead,
    output logic        MemtoReg,
    output logic [1:0]  ALUOp,
    output logic        MemWrite,
    output logic        ALUSrc,
    output logic        RegWrite
);

    // Packed strobe order: {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
    //                       ALUOp[1:0], Uncondbranch, ZeroBranch, NotZeroBranch}
    localparam logic [10:0] CTL_NOP  = 11'b0_0_0_0_0_0_00_0_0_0;
    localparam logic [10:0] CTL_LDUR = 11'b0_1_1_1_1_0_00_0_0_0;
    localparam logic [10:0] CTL_STUR = 11'b1_1_0_0_0_1_00_0_0_0;
    localparam logic [10:0] CTL_RTYP = 11'b0_0_0_1_0_0_10_0_0_0;
    localparam logic [10:0] CTL_ADDI = 11'b0_1_0_1_0_0_10_0_0_0;
    localparam logic [10:0] CTL_CBZ  = 11'b1_0_0_0_0_0_01_0_1_0;
    localparam logic [10:0] CTL_CBNZ = 11'b1_0_0_0_0_0_01_0_0_1;
    localparam logic [10:0] CTL_B    = 11'b0_0_0_0_0_0_00_1_0_0;

    logic [10:0] ctl_next;
    logic [10:0] ctl_q;

    // Masked equality: an unknown bit in a cared-about position yields a non-true
    // compare, so unknown opcodes fall through to the all-zero NOP decode.
    function automatic logic op_match(input logic [10:0] op,
                                      input logic [10:0] mask,
                                      input logic [10:0] value);
        return ((op & mask) == value);
    endfunction

    always_comb begin
        ctl_next = CTL_NOP;
        if (op_match(instruction, 11'b00111111111, 11'b00111000010))
            ctl_next = CTL_LDUR;
        else if (op_match(instruction, 11'b00111111111, 11'b00111000000))
            ctl_next = CTL_STUR;
        else if (op_match(instruction, 11'b11111111111, 11'b10001011000) ||
                 op_match(instruction, 11'b11111111111, 11'b11001011000) ||
                 op_match(instruction, 11'b11111111111, 11'b10001010000) ||
                 op_match(instruction, 11'b11111111111, 11'b10101010000))
            ctl_next = CTL_RTYP;
        else if (op_match(instruction, 11'b11111111110, 11'b10010001000))
            ctl_next = CTL_ADDI;
        else if (op_match(instruction, 11'b11111111000, 11'b10110100000))
            ctl_next = CTL_CBZ;
        else if (op_match(instruction, 11'b11111111000, 11'b10110101000))
            ctl_next = CTL_CBNZ;
        else if (op_match(instruction, 11'b11111100000, 11'b00010100000))
            ctl_next = CTL_B;
    end

    always_ff @(posedge clock) begin
        if (reset)
            ctl_q <= CTL_NOP;
        else
            ctl_q <= ctl_next;
    end

    assign Reg2Loc       = ctl_q[10];
    assign ALUSrc        = ctl_q[9];
    assign MemtoReg      = ctl_q[8];
    assign RegWrite      = ctl_q[7];
    assign MemRead       = ctl_q[6];
    assign MemWrite      = ctl_q[5];
    assign ALUOp         = ctl_q[4:3];
    assign Uncondbranch  = ctl_q[2];
    assign ZeroBranch    = ctl_q[1];
    assign NotZeroBranch = ctl_q[0];

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: table of opcodes with hand-computed strobes,
// plus reset-priority and mid-cycle-change sequences.
module tb_control_unit;

    logic        clock;
    logic        reset;
    logic [10:0] instruction;
    logic        NotZeroBranch, Reg2Loc, Uncondbranch, ZeroBranch;
    logic        MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite;
    logic [1:0]  ALUOp;

    int checks = 0;
    int errors = 0;

    control_unit dut (
        .clock         (clock),
        .reset         (reset),
        .instruction   (instruction),
        .NotZeroBranch (NotZeroBranch),
        .Reg2Loc       (Reg2Loc),
        .Uncondbranch  (Uncondbranch),
        .ZeroBranch    (ZeroBranch),
        .MemRead       (MemRead),
        .MemtoReg      (MemtoReg),
        .ALUOp         (ALUOp),
        .MemWrite      (MemWrite),
        .ALUSrc        (ALUSrc),
        .RegWrite      (RegWrite)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp, Uncondbranch, ZeroBranch, NotZeroBranch}
    localparam logic [10:0] E_NOP  = 11'b0_0_0_0_0_0_00_0_0_0;
    localparam logic [10:0] E_LDUR = 11'b0_1_1_1_1_0_00_0_0_0;
    localparam logic [10:0] E_STUR = 11'b1_1_0_0_0_1_00_0_0_0;
    localparam logic [10:0] E_RTYP = 11'b0_0_0_1_0_0_10_0_0_0;
    localparam logic [10:0] E_ADDI = 11'b0_1_0_1_0_0_10_0_0_0;
    localparam logic [10:0] E_CBZ  = 11'b1_0_0_0_0_0_01_0_1_0;
    localparam logic [10:0] E_CBNZ = 11'b1_0_0_0_0_0_01_0_0_1;
    localparam logic [10:0] E_B    = 11'b0_0_0_0_0_0_00_1_0_0;

    typedef struct {
        string       name;
        logic [10:0] op;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[19];

    function automatic logic [10:0] outs();
        return {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
                ALUOp, Uncondbranch, ZeroBranch, NotZeroBranch};
    endfunction

    task automatic check(input string name, input logic [10:0] exp);
        logic [10:0] act;
        act = outs();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
        checks++;
        if ((MemRead && MemWrite) || (RegWrite && MemWrite) ||
            (32'(Uncondbranch) + 32'(ZeroBranch) + 32'(NotZeroBranch) > 1)) begin
            errors++;
            $display("FAIL %s_exclusive: strobes %b violate exclusivity", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        vecs[0]  = '{"ldur",        11'b00111000010, E_LDUR};
        vecs[1]  = '{"ldur_hi11",   11'b11111000010, E_LDUR};
        vecs[2]  = '{"stur",        11'b00111000000, E_STUR};
        vecs[3]  = '{"stur_hi10",   11'b10111000000, E_STUR};
        vecs[4]  = '{"add",         11'b10001011000, E_RTYP};
        vecs[5]  = '{"sub",         11'b11001011000, E_RTYP};
        vecs[6]  = '{"and",         11'b10001010000, E_RTYP};
        vecs[7]  = '{"orr",         11'b10101010000, E_RTYP};
        vecs[8]  = '{"addi",        11'b10010001000, E_ADDI};
        vecs[9]  = '{"addi_lsb1",   11'b10010001001, E_ADDI};
        vecs[10] = '{"cbz",         11'b10110100000, E_CBZ};
        vecs[11] = '{"cbz_low111",  11'b10110100111, E_CBZ};
        vecs[12] = '{"cbnz",        11'b10110101000, E_CBNZ};
        vecs[13] = '{"b",           11'b00010100000, E_B};
        vecs[14] = '{"b_low_ones",  11'b00010111111, E_B};
        vecs[15] = '{"illegal_1s",  11'b11111111111, E_NOP};
        vecs[16] = '{"illegal_0s",  11'b00000000000, E_NOP};
        vecs[17] = '{"add_near",    11'b10001011001, E_NOP};
        vecs[18] = '{"ldur_near",   11'b00111000011, E_NOP};

        reset       = 1'b1;
        instruction = 11'b10001011000;
        tick();
        check("reset_add", E_NOP);
        reset = 1'b0;
        tick();
        check("post_reset_add", E_RTYP);

        for (int i = 0; i < 19; i++) begin
            instruction = vecs[i].op;
            tick();
            check(vecs[i].name, vecs[i].exp);
        end

        // reset must win over a decodable opcode and clear prior state
        instruction = 11'b00111000010;
        tick();
        check("pre_reset_ldur", E_LDUR);
        reset = 1'b1;
        tick();
        check("reset_priority", E_NOP);
        reset = 1'b0;
        tick();
        check("release_ldur", E_LDUR);

        // mid-cycle input change must not reach the outputs before the next edge
        instruction = 11'b10110100000;
        tick();
        check("mid_before", E_CBZ);
        #2 instruction = 11'b00111000000;
        #1;
        check("mid_hold", E_CBZ);
        tick();
        check("mid_after", E_STUR);
        instruction = 11'b11111111111;
        #2;
        check("illegal_hold", E_STUR);
        tick();
        check("illegal_after", E_NOP);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
